// File: rtl/am_tx.sv
// am_tx: transmit-side alignment marker inserter for a 4-lane 40GBASE-R PCS.
//
// This block sits between the per-lane scramblers and the lane gearboxes.
// After every GAP_N accepted data blocks it uses one block slot to send a
// per-lane alignment marker on all lanes at once. Upstream is stalled for
// that slot.
//
// Optional feature macro: AM_TX_BIP_EN
//   defined   : per-lane BIP3 accumulators exist. Each marker carries its
//               lane's BIP3 and BIP7 = ~BIP3.
//   undefined : there are no accumulators. Both BIP fields are 8'h00.
//               Slot timing is the same in both builds.
//
// Ports:
//   clk      in   clock
//   nreset   in   synchronous active-low reset
//   valid_i  in   data_i holds one block per lane
//   data_i   in   LANE_N*BLOCK_W, lane i at [i*BLOCK_W +: BLOCK_W]
//   ready_o  out  low only during a marker slot
//   valid_o  out  data_o is valid
//   data_o   out  registered output blocks, same lane packing as data_i
//   am_v_o   out  data_o holds alignment markers on all lanes
//
// Handshake: a block moves from data_i to data_o when valid_i && ready_o
// at a rising edge. ready_o depends only on internal state and never on
// valid_i. A marker slot is emitted whether or not valid_i is high, and
// any block offered during that slot must be held by upstream.
module am_tx #(
  parameter int LANE_N  = 4,
  parameter int BLOCK_W = 66,
  parameter int GAP_N   = 16383
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      valid_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o,
  output logic                      am_v_o
);

  // The marker table covers lanes 0..3 only, and the marker layout
  // assumes a 2-bit sync header above a 64-bit payload.
  if (LANE_N != 4) begin : g_lane_chk
    $error("am_tx: LANE_N must be 4");
  end
  if (BLOCK_W != 66) begin : g_blk_chk
    $error("am_tx: BLOCK_W must be 66");
  end
  if (GAP_N < 2) begin : g_gap_chk
    $error("am_tx: GAP_N must be >= 2");
  end

  localparam int CNT_W = $clog2(GAP_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GAP_N);

  // Fixed marker bytes per lane, packed {M6,M5,M4,M2,M1,M0}.
  // M3 and M7 are the BIP3 and BIP7 fields, so they are not stored here.
  localparam logic [47:0] AM_M [4] = '{
    48'hb8896f477690,
    48'h193b0fe6c4f0,
    48'h649a3a9b65c5,
    48'hc2865d3d79a2
  };

  // ST_MARK is the "marker pending" state. Reset enters it, so the first
  // slot after reset is always a marker.
  typedef enum logic [0:0] {
    ST_DATA = 1'b0,
    ST_MARK = 1'b1
  } state_t;

  state_t                      state;
  state_t                      state_nx;
  logic [CNT_W-1:0]            cnt;
  logic [LANE_N*BLOCK_W-1:0]   am_data;

`ifdef AM_TX_BIP_EN
  logic [7:0] bip_q [LANE_N];

  // Parity of one block: payload bit j feeds BIP3 bit j%8. The sync
  // header bits fold into BIP3 bits 3 and 4.
  function automatic logic [7:0] blk_par(input logic [BLOCK_W-1:0] b);
    logic [7:0] p;
    p = '0;
    for (int j = 0; j < 64; j++) begin
      p[j % 8] = p[j % 8] ^ b[j];
    end
    p[3] = p[3] ^ b[64];
    p[4] = p[4] ^ b[65];
    return p;
  endfunction
`endif

  // Marker blocks for the current slot, built from the running parity.
  always_comb begin
    am_data = '0;
    for (int i = 0; i < LANE_N; i++) begin
      logic [7:0] b3;
      logic [7:0] b7;
`ifdef AM_TX_BIP_EN
      b3 = bip_q[i];
      b7 = ~bip_q[i];
`else
      b3 = 8'h00;
      b7 = 8'h00;
`endif
      am_data[i*BLOCK_W +: BLOCK_W] =
        {2'b10, b7, AM_M[i][47:24], b3, AM_M[i][23:0]};
    end
  end

  // Next-state logic and ready_o.
  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    case (state)
      ST_MARK: state_nx = ST_DATA;
      ST_DATA: begin
        ready_o = 1'b1;
        // The block that brings cnt up to GAP_N makes the next slot a marker.
        if (valid_i && (cnt == CNT_LAST)) begin
          state_nx = ST_MARK;
        end
      end
      default: state_nx = ST_MARK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= ST_MARK;
      cnt     <= '0;
      valid_o <= 1'b0;
      am_v_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_MARK) begin
        data_o  <= am_data;
        valid_o <= 1'b1;
        am_v_o  <= 1'b1;
        cnt     <= '0;
      end else if (valid_i) begin
        data_o  <= data_i;
        valid_o <= 1'b1;
        am_v_o  <= 1'b0;
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        // Idle data slot: data_o keeps its last value and cnt does not move.
        valid_o <= 1'b0;
        am_v_o  <= 1'b0;
      end
    end
  end

`ifdef AM_TX_BIP_EN
  // The parity accumulators cover every emitted block, markers included.
  // When a marker goes out, the accumulator is reloaded with that marker's
  // own parity instead of being cleared.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < LANE_N; i++) begin
        bip_q[i] <= '0;
      end
    end else if (state == ST_MARK) begin
      for (int i = 0; i < LANE_N; i++) begin
        bip_q[i] <= blk_par(am_data[i*BLOCK_W +: BLOCK_W]);
      end
    end else if (valid_i) begin
      for (int i = 0; i < LANE_N; i++) begin
        bip_q[i] <= bip_q[i] ^ blk_par(data_i[i*BLOCK_W +: BLOCK_W]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_am_tx.sv
// Testbench for am_tx with GAP_N = 8.
// Random and directed stimulus is compared against a slot-level reference
// model. A stream scoreboard checks data order, and the number of data
// blocks between markers is counted.
module tb_am_tx;

  localparam int LANES = 4;
  localparam int BW    = 66;
  localparam int GAP   = 8;
  localparam int W     = LANES * BW;

  // Marker bytes M0,M1,M2,M4,M5,M6 per lane.
  localparam logic [7:0] AM_M [4][6] = '{
    '{8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8},
    '{8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19},
    '{8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64},
    '{8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2}
  };

`ifdef AM_TX_BIP_EN
  localparam logic [65:0] AM0_FIRST  =
    {2'b10, 8'hff, 8'hb8, 8'h89, 8'h6f, 8'h00, 8'h47, 8'h76, 8'h90};
  localparam logic [65:0] AM0_SECOND =
    {2'b10, 8'hef, 8'hb8, 8'h89, 8'h6f, 8'h10, 8'h47, 8'h76, 8'h90};
`else
  localparam logic [65:0] AM0_FIRST  =
    {2'b10, 8'h00, 8'hb8, 8'h89, 8'h6f, 8'h00, 8'h47, 8'h76, 8'h90};
  localparam logic [65:0] AM0_SECOND = AM0_FIRST;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         nreset;
  logic         valid_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         am_v_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  am_tx #(.LANE_N(LANES), .BLOCK_W(BW), .GAP_N(GAP)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .am_v_o  (am_v_o)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_known = 0;   // becomes 1 after the first reset
  bit           m_pending;     // the next slot is a marker
  int           m_count;       // data blocks accepted in this period
  logic [7:0]   m_bip [4];
  logic         exp_valid;
  logic         exp_am;
  bit           am_known;
  logic [W-1:0] exp_data;

  // Stream scoreboard and cadence counter.
  logic [W-1:0] exp_q [$];
  int           since_marker = 0;
  bit           period_ok = 0;

  function automatic logic [7:0] bip_of(input logic [65:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p = p ^ b[k*8 +: 8];
    p[3] = p[3] ^ b[64];
    p[4] = p[4] ^ b[65];
    return p;
  endfunction

  function automatic logic [65:0] marker(input int l, input logic [7:0] b3,
                                         input logic [7:0] b7);
    logic [7:0]  by [8];
    logic [65:0] r;
    by[0] = AM_M[l][0]; by[1] = AM_M[l][1]; by[2] = AM_M[l][2]; by[3] = b3;
    by[4] = AM_M[l][3]; by[5] = AM_M[l][4]; by[6] = AM_M[l][5]; by[7] = b7;
    r[65:64] = 2'b10;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = by[k];
    return r;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic rst_n, input logic v,
                            input logic [W-1:0] d);
    if (!rst_n) begin
      m_known   = 1;
      m_pending = 1;
      m_count   = 0;
      for (int l = 0; l < LANES; l++) m_bip[l] = 8'h00;
      exp_valid = 0;
      exp_am    = 0;
      am_known  = 1;
      exp_data  = '0;
      exp_q.delete();
      period_ok    = 0;
      since_marker = 0;
      return;
    end
    if (!m_known) return;
    if (m_pending) begin
      for (int l = 0; l < LANES; l++) begin
        logic [7:0]  b3;
        logic [7:0]  b7;
        logic [65:0] blk;
`ifdef AM_TX_BIP_EN
        b3 = m_bip[l];
        b7 = ~m_bip[l];
`else
        b3 = 8'h00;
        b7 = 8'h00;
`endif
        blk = marker(l, b3, b7);
        exp_data[l*BW +: BW] = blk;
        m_bip[l] = bip_of(blk);
      end
      exp_valid = 1; exp_am = 1; am_known = 1;
      m_pending = 0; m_count = 0;
    end else if (v) begin
      exp_data  = d;
      exp_valid = 1; exp_am = 0; am_known = 1;
      exp_q.push_back(d);
      for (int l = 0; l < LANES; l++) m_bip[l] = m_bip[l] ^ bip_of(d[l*BW +: BW]);
      m_count++;
      if (m_count == GAP) m_pending = 1;
    end else begin
      exp_valid = 0;
      am_known  = 0;
    end
  endtask

  // Compare the DUT outputs with the model at the current negedge.
  task automatic check_outputs();
    if (!m_known) return;
    check("ready", W'(ready_o), W'(!m_pending));
    check("valid", W'(valid_o), W'(exp_valid));
    check("data",  data_o, exp_data);
    if (am_known) check("am_v", W'(am_v_o), W'(exp_am));
    if (valid_o && !am_v_o) begin
      check("sb_nonempty", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) check("sb_data", data_o, exp_q.pop_front());
      since_marker++;
    end
    if (valid_o && am_v_o) begin
      if (period_ok) check("gap", W'(since_marker), W'(GAP));
      period_ok    = 1;
      since_marker = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst_n, input logic v, input logic [W-1:0] d);
    check_outputs();
    nreset  = rst_n;
    valid_i = v;
    data_i  = d;
    model_step(rst_n, v, d);
    @(negedge clk);
  endtask

  int tag = 1;

  function automatic logic [W-1:0] make_block(input int t, input int mode);
    logic [W-1:0] d;
    for (int l = 0; l < LANES; l++) begin
      if (mode == 3)      d[l*BW +: BW] = {2'b01, 64'h0};
      else if (mode == 2) d[l*BW +: BW] = {2'($urandom_range(0, 3)), $urandom(), $urandom()};
      else                d[l*BW +: BW] = {2'b01, 32'(t), 24'h0, 8'(l)};
    end
    return d;
  endfunction

  // mode 0: always valid, 1: valid toggles, 2: random valid/data/reset,
  // 3: always valid, all-zero payload with sync header 01
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic v;
      logic r;
      r = 1'b1;
      case (mode)
        1:       v = (i % 2 == 0);
        2: begin
          v = ($urandom_range(0, 9) < 7);
          r = ($urandom_range(0, 59) != 0);
        end
        default: v = 1'b1;
      endcase
      if (r && v && m_known && !m_pending) begin
        cycle(r, v, make_block(tag, mode));
        tag++;
      end else begin
        cycle(r, v, make_block(tag, mode));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nreset  = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    @(negedge clk);

    // Reset, then continuous tagged traffic.
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, make_block(0, 0));
    run(1, 0);
    check("first_am_valid", W'(am_v_o), W'(1));
    check("first_am_ready", W'(ready_o), W'(1));
    check("first_am_lane0", W'(data_o[65:0]), W'(AM0_FIRST));
    run(3 * (GAP + 1), 0);

    // Constant {01, 0} data: the second marker's parity is known in advance.
    cycle(1'b0, 1'b0, '0);
    run(GAP + 2, 3);
    check("second_am_flag",  W'(am_v_o), W'(1));
    check("second_am_lane0", W'(data_o[65:0]), W'(AM0_SECOND));

    // valid_i toggling.
    run(4 * (GAP + 1), 1);

    // valid_i low exactly when the marker is due.
    for (int k = 0; k < 2 * GAP && !m_pending; k++) run(1, 0);
    cycle(1'b1, 1'b0, make_block(tag, 0));
    check("due_valid", W'(valid_o), W'(1));
    check("due_am",    W'(am_v_o),  W'(1));
    run(GAP + 3, 0);

    // Reset in the middle of a period, after block 5.
    cycle(1'b0, 1'b0, '0);
    run(6, 0);
    cycle(1'b0, 1'b1, make_block(tag, 0));
    run(1, 0);
    check("rst_am",   W'(am_v_o), W'(1));
    check("rst_bip3", W'(data_o[31:24]), W'(8'h00));
    run(2 * (GAP + 1), 0);

    // Random traffic with occasional resets.
    run(400, 2);

    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
